rle_block_decoder: RTL and testbench
====================================

# rle_block_decoder

Run-length expander for the DCT+RLE compression path, used on the decompression side. It accepts (value, run) pairs of quantised DCT coefficients and replays each value `run` times into an 8-coefficient block stream. The output carries the coefficient index and a block-last flag, so a downstream IDCT stage can rebuild the 8-point coefficient vectors that the per-frequency DCT units produced. Back-to-back pairs sustain one coefficient per cycle.

## Interface
Parameters:
- DATA_W, 19, coefficient width (signed, matches DCT output width)
- RUN_W, 4, run-length field width
- BLOCK_LEN, 8, coefficients per block (power of two)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pair available
- in_ready  out  1  decoder can accept pair this cycle
- in_value  in  DATA_W  signed coefficient value
- in_run  in  RUN_W  repetition count, legal range 1..BLOCK_LEN
- out_valid  out  1  coefficient available
- out_ready  in  1  downstream accepts coefficient
- out_data  out  DATA_W  signed coefficient
- out_index  out  log2(BLOCK_LEN)  position within block, 0..BLOCK_LEN-1
- out_last  out  1  high when out_index == BLOCK_LEN-1
- block_cnt  out  16  completed blocks, wraps at 65535 -> 0
- err  out  1  sticky protocol error flag

## Operation
- State registers:
  - val_r: held value
  - rem_r: remaining copies, 0..BLOCK_LEN
  - idx_r: next output index
  - block_cnt
  - err
- Events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Two states:
  - EMPTY (rem_r == 0): out_valid = 0, in_ready = 1.
  - EXPAND (rem_r != 0): out_valid = 1, out_data = val_r, out_index = idx_r.
- in_ready = !rst & (rem_r == 0 | (rem_r == 1 & out_ready)). This permits a zero-bubble handover between pairs.
- On out_fire:
  - idx_r increments; wraps BLOCK_LEN-1 -> 0.
  - rem_r decrements.
  - If out_last, block_cnt increments.
- On in_fire:
  - val_r <= in_value.
  - rem_r <= clipped run; no decrement is applied in that cycle.
  - Slots left = BLOCK_LEN - idx_next, where idx_next is idx_r after any same-cycle out_fire increment and wrap.
- Run clipping:
  - in_run == 0: load 1, set err.
  - in_run > slots left: load slots left, set err. Runs never cross a block boundary.
  - Otherwise load in_run.
- err clears only on reset.
- in_value is passed through unchanged. No sign extension or arithmetic is applied.

## Timing
- Reset values: out_valid 0, out_data 0, out_index 0, out_last 0, block_cnt 0, err 0, in_ready 0 while rst is high.
- in_ready = 1 in the first cycle after rst deasserts.
- Latency: pair accepted at edge N gives out_valid = 1 from cycle N+1.
- Throughput: a run of k emits k coefficients in k consecutive cycles when out_ready is held high.
- Chained pairs: the next pair may be accepted in the same cycle as the last copy of the current one, so there is no idle cycle.
- Backpressure:
  - out_ready = 0 holds out_data, out_index and out_valid stable.
  - in_ready falls once rem_r > 1, or once rem_r == 1 with out_ready low.
- Reset mid-run: rem_r, idx_r, block_cnt and err clear immediately. Partially expanded blocks are discarded.
- block_cnt wrap: 65535 + 1 -> 0. err is not set on wrap.

## Test plan
- Reset, then pairs (5,3),(-2,1),(0,4) with out_ready = 1 -> 8 consecutive outputs 5,5,5,-2,0,0,0,0; indices 0..7; out_last only on the 8th; block_cnt = 1; err = 0.
- Pair (7,8) followed immediately by (9,8) -> 16 outputs with no gap; out_index wraps 7 -> 0 between the two runs; block_cnt = 2.
- Pairs (1,6) then (2,5) -> the second run is clipped to 2 (outputs 1×6, 2×2); err = 1; the next pair's first output has out_index 0.
- in_run = 0 with value -100 -> a single output -100; err = 1 and stays high until reset.
- Pair (3,4), toggle out_ready 1,0,0,1,1,0,1 -> each output is held stable while stalled; exactly 4 out_fires; in_ready stays low until rem_r == 1 with out_ready = 1.
- Assert rst after the 3rd output of (4,8) -> out_valid = 0 and block_cnt = 0 immediately; after release, pair (6,8) starts at out_index 0.

Source files
------------

// File: rtl/rle_block_decoder_if.sv
// Handshake bundle for the run-length block decoder.
// Input pairs, output coefficient stream and status counters.
interface rle_block_decoder_if #(
    parameter int DATA_W    = 19,
    parameter int RUN_W     = 4,
    parameter int BLOCK_LEN = 8
) ();
    localparam int IDX_W = $clog2(BLOCK_LEN);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_value;
    logic [RUN_W-1:0]         in_run;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]         out_index;
    logic                     out_last;
    logic [15:0]              block_cnt;
    logic                     err;

    modport master (
        output in_valid, in_value, in_run, out_ready,
        input  in_ready, out_valid, out_data, out_index,
        input  out_last, block_cnt, err
    );

    modport slave (
        input  in_valid, in_value, in_run, out_ready,
        output in_ready, out_valid, out_data, out_index,
        output out_last, block_cnt, err
    );
endinterface

// File: rtl/rle_block_decoder.sv
// Run-length expander: replays (value, run) pairs into
// fixed-length coefficient blocks, one coefficient per cycle.
module rle_block_decoder #(
    parameter int DATA_W    = 19,
    parameter int RUN_W     = 4,
    parameter int BLOCK_LEN = 8
) (
    input logic              clk,
    input logic              rst,
    rle_block_decoder_if.slave bus
);
    localparam int IDX_W = $clog2(BLOCK_LEN);
    localparam int REM_W = IDX_W + 1;
    localparam int CW    = (RUN_W > REM_W) ? RUN_W : REM_W;

    typedef enum logic {EMPTY, EXPAND} state_t;

    logic signed [DATA_W-1:0] r_val;
    logic [REM_W-1:0]         r_rem;
    logic [IDX_W-1:0]         r_idx;
    logic [15:0]              r_block_cnt;
    logic                     r_err;

    state_t                   w_state;
    logic                     w_last;
    logic                     w_in_ready;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic                     w_run_zero;
    logic                     w_run_over;
    logic [CW-1:0]            w_slots;
    logic [CW-1:0]            w_run;
    logic [REM_W-1:0]         w_rem_load;
    logic [IDX_W-1:0]         w_idx_next;
    logic [REM_W-1:0]         w_rem_next;
    logic [15:0]              w_block_next;
    logic                     w_err_next;
    logic signed [DATA_W-1:0] w_val_next;

    // State decode and handshake events; a pair may be taken while the last copy drains
    always_comb begin
        w_state    = (r_rem == '0) ? EMPTY : EXPAND;
        w_last     = (w_state == EXPAND) && (r_idx == IDX_W'(BLOCK_LEN - 1));
        w_in_ready = !rst && ((r_rem == '0) ||
                     ((r_rem == REM_W'(1)) && bus.out_ready));
        w_out_fire = (w_state == EXPAND) && bus.out_ready;
        w_in_fire  = bus.in_valid && w_in_ready;
    end

    // Next-state: drain one copy, then optionally load a clipped run that stays inside the block
    always_comb begin
        w_idx_next   = r_idx;
        w_rem_next   = r_rem;
        w_block_next = r_block_cnt;
        w_err_next   = r_err;
        w_val_next   = r_val;
        if (w_out_fire) begin
            w_idx_next = r_idx + 1'b1;
            w_rem_next = r_rem - 1'b1;
            if (w_last) begin
                w_block_next = r_block_cnt + 16'd1;
            end
        end
        w_slots    = CW'(BLOCK_LEN) - CW'(w_idx_next);
        w_run      = CW'(bus.in_run);
        w_run_zero = (bus.in_run == '0);
        w_run_over = (w_run > w_slots);
        if (w_run_zero) begin
            w_rem_load = REM_W'(1);
        end else if (w_run_over) begin
            w_rem_load = REM_W'(w_slots);
        end else begin
            w_rem_load = REM_W'(w_run);
        end
        if (w_in_fire) begin
            w_val_next = bus.in_value;
            w_rem_next = w_rem_load;
            if (w_run_zero || w_run_over) begin
                w_err_next = 1'b1;
            end
        end
    end

    // State registers; reset discards any partially expanded block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val       <= '0;
            r_rem       <= '0;
            r_idx       <= '0;
            r_block_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_val       <= w_val_next;
            r_rem       <= w_rem_next;
            r_idx       <= w_idx_next;
            r_block_cnt <= w_block_next;
            r_err       <= w_err_next;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (w_state == EXPAND);
    assign bus.out_data  = (w_state == EXPAND) ? r_val : '0;
    assign bus.out_index = r_idx;
    assign bus.out_last  = w_last;
    assign bus.block_cnt = r_block_cnt;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_rle_block_decoder.sv
// Directed bench for rle_block_decoder with a queue-based
// expansion model checked every cycle at the falling edge.
module tb_rle_block_decoder;
    localparam int DATA_W = 19;
    localparam int RUN_W  = 4;
    localparam int BL     = 8;

    typedef struct {
        int d;
        int i;
        bit l;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   fire_cnt = 0;

    exp_t q[$];
    int   m_pos = 0;
    int   m_blocks = 0;
    bit   m_err = 1'b0;

    int   log_d[$];
    int   log_i[$];
    int   log_l[$];
    int   log_t[$];

    bit   prev_valid = 1'b0;
    bit   prev_ready = 1'b0;
    int   prev_d = 0;
    int   prev_i = 0;

    rle_block_decoder_if #(.DATA_W(DATA_W), .RUN_W(RUN_W), .BLOCK_LEN(BL)) bus ();

    rle_block_decoder #(.DATA_W(DATA_W), .RUN_W(RUN_W), .BLOCK_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expand a pair into the expected coefficient list
    task automatic m_push(input int v, input int r);
        int n;
        int slots;
        n = r;
        if (n == 0) begin
            n = 1;
            m_err = 1'b1;
        end
        slots = BL - m_pos;
        if (n > slots) begin
            n = slots;
            m_err = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.d = v;
            e.i = m_pos;
            e.l = (m_pos == BL - 1);
            q.push_back(e);
            m_pos = (m_pos + 1) % BL;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_out_data", int'(bus.out_data), 0);
            check("rst_out_index", int'(bus.out_index), 0);
            check("rst_out_last", int'(bus.out_last), 0);
            check("rst_block_cnt", int'(bus.block_cnt), 0);
            check("rst_err", int'(bus.err), 0);
            check("rst_in_ready", int'(bus.in_ready), 0);
            q.delete();
            m_pos = 0;
            m_blocks = 0;
            m_err = 1'b0;
            prev_valid = 1'b0;
        end else begin
            check("in_ready", int'(bus.in_ready),
                  int'((q.size() == 0) || (q.size() == 1 && bus.out_ready)));
            check("out_valid", int'(bus.out_valid), int'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_data", int'(bus.out_data), q[0].d);
                check("out_index", int'(bus.out_index), q[0].i);
                check("out_last", int'(bus.out_last), int'(q[0].l));
            end
            check("block_cnt", int'(bus.block_cnt), m_blocks);
            check("err", int'(bus.err), int'(m_err));
            if (prev_valid && !prev_ready) begin
                check("stall_valid", int'(bus.out_valid), 1);
                check("stall_data", int'(bus.out_data), prev_d);
                check("stall_index", int'(bus.out_index), prev_i);
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_d = int'(bus.out_data);
            prev_i = int'(bus.out_index);
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                if (e.l) m_blocks = (m_blocks + 1) % 65536;
                log_d.push_back(int'(bus.out_data));
                log_i.push_back(int'(bus.out_index));
                log_l.push_back(int'(bus.out_last));
                log_t.push_back(cyc);
                fire_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                m_push(int'(bus.in_value), int'(bus.in_run));
            end
        end
    end

    task automatic clear_logs();
        log_d.delete();
        log_i.delete();
        log_l.delete();
        log_t.delete();
        fire_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_rst", int'(bus.in_ready), 1);
    endtask

    task automatic send(input int v, input int r);
        bit ok;
        ok = 1'b0;
        bus.in_value = DATA_W'(v);
        bus.in_run = RUN_W'(r);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accept", int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", int'(ok), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int e1[8];
        int pat[7];
        bit ok;
        e1 = '{5, 5, 5, -2, 0, 0, 0, 0};
        pat = '{1, 0, 0, 1, 1, 0, 1};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.in_run = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("lit_rst_ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        check("lit_first_ready", int'(bus.in_ready), 1);

        // basic block
        clear_logs();
        send(5, 3);
        send(-2, 1);
        send(0, 4);
        drain();
        check("t1_count", log_d.size(), 8);
        for (int i = 0; i < 8 && i < log_d.size(); i++) begin
            check("t1_data", log_d[i], e1[i]);
            check("t1_index", log_i[i], i);
            check("t1_last", log_l[i], int'(i == 7));
        end
        if (log_t.size() == 8) check("t1_span", log_t[7] - log_t[0], 7);
        check("t1_blocks", int'(bus.block_cnt), 1);
        check("t1_err", int'(bus.err), 0);

        // two full blocks back to back
        do_reset();
        clear_logs();
        send(7, 8);
        send(9, 8);
        drain();
        check("t2_count", log_d.size(), 16);
        if (log_d.size() == 16) begin
            check("t2_d7", log_d[7], 7);
            check("t2_d8", log_d[8], 9);
            check("t2_i7", log_i[7], 7);
            check("t2_i8", log_i[8], 0);
            check("t2_span", log_t[15] - log_t[0], 15);
        end
        check("t2_blocks", int'(bus.block_cnt), 2);

        // run clipped at block boundary
        do_reset();
        clear_logs();
        send(1, 6);
        send(2, 5);
        send(8, 1);
        drain();
        check("t3_count", log_d.size(), 9);
        if (log_d.size() == 9) begin
            check("t3_d5", log_d[5], 1);
            check("t3_d6", log_d[6], 2);
            check("t3_d7", log_d[7], 2);
            check("t3_d8", log_d[8], 8);
            check("t3_i8", log_i[8], 0);
        end
        check("t3_err", int'(bus.err), 1);

        // zero run
        do_reset();
        clear_logs();
        send(-100, 0);
        send(11, 2);
        drain();
        check("t4_count", log_d.size(), 3);
        if (log_d.size() == 3) begin
            check("t4_d0", log_d[0], -100);
            check("t4_i1", log_i[1], 1);
        end
        repeat (5) @(posedge clk);
        #1;
        check("t4_err_sticky", int'(bus.err), 1);

        // backpressure
        do_reset();
        clear_logs();
        send(3, 4);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = pat[i][0];
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        check("t5_fires", fire_cnt, 4);
        check("t5_idle", int'(bus.out_valid), 0);
        drain();

        // reset mid-run
        do_reset();
        send(1, 8);
        drain();
        check("t6_pre_blocks", int'(bus.block_cnt), 1);
        clear_logs();
        send(4, 8);
        bus.in_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (fire_cnt >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_reach3", int'(ok), 1);
        rst = 1'b1;
        #1;
        check("t6_valid", int'(bus.out_valid), 0);
        check("t6_blocks", int'(bus.block_cnt), 0);
        check("t6_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t6_ready_rel", int'(bus.in_ready), 1);
        clear_logs();
        send(6, 8);
        drain();
        check("t6_count", log_d.size(), 8);
        if (log_d.size() == 8) begin
            check("t6_i0", log_i[0], 0);
            check("t6_d0", log_d[0], 6);
        end
        check("t6_blocks_end", int'(bus.block_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
